// File: rtl/serial_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_tx_pkg
// Shared definitions for the serial transmitter arbiter:
//   - state_t     : 3-bit FSM state encoding (IDLE, START, WAITB, XFER, DONE)
//   - TIMEOUT_DEF : default frame timeout in clock cycles
// -----------------------------------------------------------------------------
package serial_tx_pkg;

  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAITB = 3'd2,
    XFER  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/serial_tx_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Scans requests starting at ptr+1 and
// wrapping modulo N_REQ; the first set request wins.
// Ports:
//   req [N_REQ-1:0] in  : request vector
//   ptr [IDX_W-1:0] in  : index of the most recently served requester
//   idx [IDX_W-1:0] out : winning requester index (0 when any=0)
//   any             out : at least one request is set
// -----------------------------------------------------------------------------
module rr_picker
  import serial_tx_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Distance 1 is checked first, so the last-served requester (distance
  // N_REQ) is only chosen when nobody else is asking.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int d = 1; d <= N_REQ; d++) begin
      if (!any && req[(int'(ptr) + d) % N_REQ]) begin
        any = 1'b1;
        idx = IDX_W'((int'(ptr) + d) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// -----------------------------------------------------------------------------
// serial_tx_arbiter
// Shares one serial transmitter among N_REQ requesters using round-robin
// arbitration. Pulses the transmitter start, steers the granted requester's
// serial bit into the transmitter and uses the rdy handshake to detect the end
// of a frame. A frame that runs TIMEOUT cycles without finishing is aborted.
// Ports:
//   clk             in  : clock, rising edge
//   rst             in  : asynchronous active-low reset
//   req   [N_REQ]   in  : level request per requester, held until done
//   serIn [N_REQ]   in  : serial data bit per requester
//   gnt   [N_REQ]   out : one-hot grant, 0 when idle
//   done  [N_REQ]   out : one-cycle end-of-frame pulse to the granted requester
//   err             out : one-cycle pulse on timeout abort
//   txStrt          out : transmitter start pulse
//   txSerIn         out : serial bit steered to the transmitter
//   txRdy           in  : transmitter ready (low while busy)
//   txSerOutValid   in  : transmitter output-valid, counted for debug only
// -----------------------------------------------------------------------------
module serial_tx_arbiter
  import serial_tx_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] serIn,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             err,
  output logic             txStrt,
  output logic             txSerIn,
  input  logic             txRdy,
  input  logic             txSerOutValid
);

  localparam int CNT_W = $clog2(TIMEOUT);
  // A frame never outlasts TIMEOUT cycles, so one extra bit cannot overflow.
  localparam int FB_W  = CNT_W + 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_q, err_d;
  logic             strt_q, strt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FB_W-1:0]  frame_bits_q, frame_bits_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             timeout;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  rr_picker #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_picker (
    .req(req),
    .ptr(ptr_q),
    .idx(pick_idx),
    .any(pick_any)
  );

  // All control outputs are registered: each takes effect on the edge that
  // leaves the state deciding it. gnt rises leaving IDLE, txStrt one cycle
  // later leaving START, done/err together with gnt falling.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    done_d       = '0;
    err_d        = 1'b0;
    strt_d       = 1'b0;
    cnt_d        = cnt_q;
    timeout      = (cnt_q == CNT_W'(TIMEOUT - 1));
    frame_bits_d = (state_q == START) ? '0 : frame_bits_q + FB_W'(txSerOutValid);

    case (state_q)
      IDLE: begin
        if (pick_any && txRdy) begin
          idx_d   = pick_idx;
          gnt_d   = onehot(pick_idx);
          state_d = START;
        end
      end
      START: begin
        strt_d  = 1'b1;
        cnt_d   = '0;
        state_d = WAITB;
      end
      WAITB, XFER: begin
        cnt_d = cnt_q + 1'b1;
        // Timeout wins over every other exit: the frame is abandoned and the
        // requester gets err instead of done.
        if (timeout) begin
          err_d   = 1'b1;
          gnt_d   = '0;
          ptr_d   = idx_q;
          state_d = IDLE;
        end else if (state_q == WAITB) begin
          if (!txRdy) state_d = XFER;
        end else if (txRdy) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          ptr_d   = idx_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      ptr_q        <= IDX_W'(N_REQ - 1);
      gnt_q        <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      strt_q       <= 1'b0;
      cnt_q        <= '0;
      frame_bits_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      strt_q       <= strt_d;
      cnt_q        <= cnt_d;
      frame_bits_q <= frame_bits_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign txStrt  = strt_q;
  assign txSerIn = (|gnt_q) ? serIn[idx_q] : 1'b0;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_serial_tx_arbiter
// Self-checking bench for serial_tx_arbiter (N_REQ=4, TIMEOUT=64). A simple
// transmitter model answers txStrt with a busy period of chosen length; the
// expected grant order and event timing come from the round-robin rule and the
// frame timeline (gnt, then txStrt, then done one cycle after rdy returns).
// -----------------------------------------------------------------------------
module tb_serial_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 64;

  logic       clk, rst;
  logic [3:0] req, serIn, gnt, done;
  logic       err, txStrt, txSerIn, txRdy, txSerOutValid;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // transmitter model: mode 0 = answers start, 1 = never busy, 2 = bench drives txRdy
  int   tx_mode      = 0;
  int   busy_left    = 0;
  int   busy_len     = 3;
  int   rdy_rise_cyc = -1;
  logic prev_strt    = 1'b0;

  int m_ptr         = N - 1;
  int last_done_cyc = 0;

  serial_tx_arbiter #(.N_REQ(N), .IDX_W(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .serIn(serIn), .gnt(gnt), .done(done),
    .err(err), .txStrt(txStrt), .txSerIn(txSerIn), .txRdy(txRdy),
    .txSerOutValid(txSerOutValid)
  );

  initial clk = 1'b0;
  always #100 clk = ~clk;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    int c;
    for (int d = 1; d <= N; d++) begin
      c = (p + d) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
    if (tx_mode == 0) begin
      if (prev_strt) begin
        txRdy     = 1'b0;
        busy_left = busy_len;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          txRdy        = 1'b1;
          rdy_rise_cyc = cyc;
        end
      end
    end
    prev_strt     = txStrt;
    txSerOutValid = (tx_mode == 0 && !txRdy) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic model_reset();
    txRdy     = 1'b1;
    busy_left = 0;
    prev_strt = 1'b0;
    m_ptr     = N - 1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = 4'b0;
    tx_mode = 0;
    model_reset();
    step();
    step();
    rst = 1'b1;
  endtask

  // One full frame for requester w; gnt expected at exp_cyc. On done, req is
  // updated to (req & ~clr) | set, as a requester would react to its done.
  task automatic test_frame(input int w, input int exp_cyc, input int blen,
                            input logic [3:0] clr, input logic [3:0] set);
    logic [3:0] oh;
    int  dcyc;
    bit  got;
    oh       = 4'(1 << w);
    busy_len = blen;
    got      = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (gnt !== 4'b0) got = 1'b1;
      else step();
    end
    n_checks++;
    if (gnt !== oh) begin
      n_fail++; $display("FAIL frame_gnt: gnt=%b expected %b (cyc %0d)", gnt, oh, cyc);
    end
    n_checks++;
    if (cyc != exp_cyc) begin
      n_fail++; $display("FAIL frame_gnt_latency: gnt at cyc %0d expected %0d", cyc, exp_cyc);
    end
    step();
    n_checks++;
    if (txStrt !== 1'b1 || gnt !== oh) begin
      n_fail++; $display("FAIL frame_start: txStrt=%b gnt=%b expected 1 %b", txStrt, gnt, oh);
    end
    step();
    n_checks++;
    if (txStrt !== 1'b0) begin
      n_fail++; $display("FAIL frame_start_pulse: txStrt=%b expected 0", txStrt);
    end
    dcyc = -1;
    for (int i = 0; i < 40 && dcyc < 0; i++) begin
      serIn = 4'($urandom);
      #1;
      n_checks++;
      if (txSerIn !== serIn[w]) begin
        n_fail++; $display("FAIL frame_txserin: txSerIn=%b expected %b", txSerIn, serIn[w]);
      end
      step();
      if (done !== 4'b0) dcyc = cyc;
      else begin
        n_checks++;
        if (gnt !== oh || err !== 1'b0) begin
          n_fail++; $display("FAIL frame_hold: gnt=%b err=%b expected %b 0", gnt, err, oh);
        end
      end
    end
    n_checks++;
    if (done !== oh || gnt !== 4'b0 || dcyc != rdy_rise_cyc + 1) begin
      n_fail++;
      $display("FAIL frame_done: done=%b gnt=%b at cyc %0d expected %b 0000 at cyc %0d",
               done, gnt, dcyc, oh, rdy_rise_cyc + 1);
    end
    serIn = 4'hF;
    #1;
    n_checks++;
    if (txSerIn !== 1'b0) begin
      n_fail++; $display("FAIL frame_idle_txserin: txSerIn=%b expected 0", txSerIn);
    end
    m_ptr         = w;
    last_done_cyc = cyc;
    req           = (req & ~clr) | set;
    step();
    n_checks++;
    if (done !== 4'b0) begin
      n_fail++; $display("FAIL frame_done_pulse: done=%b expected 0000", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'b0;
    serIn = 4'hF;
    txSerOutValid = 1'b0;
    model_reset();
    step();
    step();
    #1;
    n_checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || err !== 1'b0 || txStrt !== 1'b0 || txSerIn !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt=%b done=%b err=%b txStrt=%b txSerIn=%b expected all 0",
               gnt, done, err, txStrt, txSerIn);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (gnt !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle_gnt: gnt=%b expected 0000", gnt);
    end
  endtask

  task automatic test_single();
    req = 4'b0100;
    test_frame(2, cyc + 1, 4, 4'b0100, 4'b0);
  endtask

  task automatic test_round_robin();
    int w, exp_c;
    do_reset();
    req   = 4'b1111;
    exp_c = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      w = rr_pick(req, m_ptr);
      test_frame(w, exp_c, 1 + (k % 3), (k == 4) ? 4'b1111 : 4'b0000, 4'b0);
      exp_c = last_done_cyc + 2;
    end
  endtask

  task automatic test_txserin();
    logic p;
    logic [2:0] pat;
    tx_mode = 2;
    txRdy   = 1'b1;
    req     = 4'b0010;
    step();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++; $display("FAIL txserin_gnt: gnt=%b expected 0010", gnt);
    end
    pat = 3'b101;
    for (int k = 0; k < 3; k++) begin
      p     = pat[2 - k];
      serIn = 4'($urandom);
      serIn[1] = p;
      #1;
      n_checks++;
      if (txSerIn !== p) begin
        n_fail++; $display("FAIL txserin_bit: txSerIn=%b expected %b", txSerIn, p);
      end
      serIn = serIn ^ 4'b1101;
      #1;
      n_checks++;
      if (txSerIn !== p) begin
        n_fail++; $display("FAIL txserin_other_bits: txSerIn=%b expected %b", txSerIn, p);
      end
      if (k < 2) step();
    end
    txRdy = 1'b0;
    step();
    step();
    txRdy = 1'b1;
    step();
    n_checks++;
    if (done !== 4'b0010 || gnt !== 4'b0) begin
      n_fail++; $display("FAIL txserin_done: done=%b gnt=%b expected 0010 0000", done, gnt);
    end
    req = 4'b0;
    step();
    m_ptr   = 1;
    tx_mode = 0;
  endtask

  task automatic test_timeout();
    int w1, w2, strt_cyc, ecyc;
    logic [3:0] oh1;
    tx_mode = 1;
    txRdy   = 1'b1;
    req     = 4'b0011;
    w1      = rr_pick(req, m_ptr);
    oh1     = 4'(1 << w1);
    step();
    n_checks++;
    if (gnt !== oh1) begin
      n_fail++; $display("FAIL timeout_gnt: gnt=%b expected %b", gnt, oh1);
    end
    step();
    strt_cyc = cyc;
    n_checks++;
    if (txStrt !== 1'b1) begin
      n_fail++; $display("FAIL timeout_start: txStrt=%b expected 1", txStrt);
    end
    ecyc = -1;
    for (int i = 0; i < TO + 10 && ecyc < 0; i++) begin
      step();
      if (err !== 1'b0) ecyc = cyc;
      else begin
        n_checks++;
        if (done !== 4'b0 || gnt !== oh1) begin
          n_fail++; $display("FAIL timeout_hold: done=%b gnt=%b expected 0000 %b", done, gnt, oh1);
        end
      end
    end
    n_checks++;
    if (err !== 1'b1 || gnt !== 4'b0 || done !== 4'b0 || ecyc != strt_cyc + TO) begin
      n_fail++;
      $display("FAIL timeout_err: err=%b gnt=%b done=%b at cyc %0d expected 1 0000 0000 at cyc %0d",
               err, gnt, done, ecyc, strt_cyc + TO);
    end
    m_ptr   = w1;
    req[w1] = 1'b0;
    w2      = rr_pick(req, m_ptr);
    tx_mode = 0;
    step();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_err_pulse: err=%b expected 0", err);
    end
    test_frame(w2, ecyc + 1, 4, 4'(1 << w2), 4'b0);
  endtask

  task automatic test_txrdy_idle();
    tx_mode = 2;
    txRdy   = 1'b0;
    req     = 4'b0;
    for (int i = 0; i < 3; i++) step();
    req = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (gnt !== 4'b0) begin
        n_fail++; $display("FAIL rdy_low_gnt: gnt=%b expected 0000", gnt);
      end
    end
    txRdy     = 1'b1;
    busy_left = 0;
    prev_strt = 1'b0;
    tx_mode   = 0;
    test_frame(3, cyc + 1, 5, 4'b1000, 4'b0);
  endtask

  task automatic test_reset_mid();
    busy_len = 10;
    req      = 4'b1000;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (gnt !== 4'b1000) begin
      n_fail++; $display("FAIL rstmid_pre_gnt: gnt=%b expected 1000", gnt);
    end
    #20;
    rst = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 4'b0 || txStrt !== 1'b0 || done !== 4'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: gnt=%b txStrt=%b done=%b err=%b expected all 0",
               gnt, txStrt, done, err);
    end
    model_reset();
    step();
    n_checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_hold: gnt=%b done=%b err=%b expected all 0", gnt, done, err);
    end
    rst = 1'b1;
    req = 4'b1111;
    test_frame(0, cyc + 1, 3, 4'b1111, 4'b0);
  endtask

  task automatic test_random();
    int w, exp_c;
    logic [3:0] clr, set;
    req = 4'($urandom_range(1, 15));
    exp_c = cyc + 1;
    for (int k = 0; k < 25; k++) begin
      w   = rr_pick(req, m_ptr);
      clr = ($urandom_range(0, 3) != 0) ? 4'(1 << w) : 4'b0;
      set = 4'($urandom) & 4'($urandom);
      test_frame(w, exp_c, $urandom_range(1, 12), clr, set);
      if (req == 4'b0) req = 4'($urandom_range(1, 15));
      exp_c = last_done_cyc + 2;
    end
    req = 4'b0;
    step();
    step();
  endtask

  initial begin
    rst = 1'b0;
    req = 4'b0;
    serIn = 4'b0;
    txRdy = 1'b1;
    txSerOutValid = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_txserin();
    test_timeout();
    test_txrdy_idle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(200.0 * 20000);
    $display("FAIL watchdog: simulation still running at cyc %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
